// File: rtl/time_date_counter_pkg.sv
// Shared RTC field limits, widths and the calendar month-length function
// (also used by the keyboard set/edit logic).
package time_date_counter_pkg;

  localparam int unsigned SEG_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HORA_W = 5;
  localparam int unsigned YEAR_W = 7;
  localparam int unsigned MES_W  = 4;
  localparam int unsigned DIA_W  = 5;

  localparam logic [SEG_W-1:0]  SEG_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HORA_W-1:0] HORA_MAX = 5'd23;
  localparam logic [YEAR_W-1:0] YEAR_MAX = 7'd99;
  localparam logic [MES_W-1:0]  MES_MAX  = 4'd12;

  // Leap rule year%4==0 is exact for 2000-2099; invalid months give 0.
  function automatic logic [DIA_W-1:0] days_in_month(input logic [MES_W-1:0]  mes,
                                                     input logic [YEAR_W-1:0] year);
    logic [DIA_W-1:0] d;
    d = '0;
    case (mes)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
      4'd2:    d = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/time_date_counter_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV cycles of run=1; clr restarts the phase.
module tick_gen #(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/time_date_counter.sv
// RTC core: 1 Hz prescaler plus cascaded time/date counters with validated loads.
module time_date_counter
  import time_date_counter_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load_time,
  input  logic              load_date,
  input  logic [SEG_W-1:0]  set_seg,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [HORA_W-1:0] set_hora,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [MES_W-1:0]  set_mes,
  input  logic [DIA_W-1:0]  set_dia,
  output logic [SEG_W-1:0]  Cuenta_Segundos,
  output logic [MIN_W-1:0]  Cuenta_Minutos,
  output logic [HORA_W-1:0] Cuenta_Horas,
  output logic [YEAR_W-1:0] Cuenta_Year,
  output logic [MES_W-1:0]  Cuenta_Mes,
  output logic [DIA_W-1:0]  Cuenta_Dia,
  output logic              tick_1hz,
  output logic              load_err
);

  logic tick;
  logic time_ok, date_ok;
  logic sec_wrap, min_wrap, hora_wrap, dia_wrap, mes_wrap, year_wrap;
  logic day_carry;

  assign time_ok = (set_seg <= SEG_MAX) && (set_min <= MIN_MAX) && (set_hora <= HORA_MAX);
  assign date_ok = (set_year <= YEAR_MAX) && (set_mes != '0) && (set_mes <= MES_MAX) &&
                   (set_dia != '0) && (set_dia <= days_in_month(set_mes, set_year));

  assign sec_wrap  = (Cuenta_Segundos == SEG_MAX);
  assign min_wrap  = (Cuenta_Minutos == MIN_MAX);
  assign hora_wrap = (Cuenta_Horas == HORA_MAX);
  assign dia_wrap  = (Cuenta_Dia == days_in_month(Cuenta_Mes, Cuenta_Year));
  assign mes_wrap  = (Cuenta_Mes == MES_MAX);
  assign year_wrap = (Cuenta_Year == YEAR_MAX);

  // A load_time strobe owns the time group this edge, so its rollover cannot carry.
  assign day_carry = tick && !load_time && sec_wrap && min_wrap && hora_wrap;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clr   (load_time && time_ok),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Cuenta_Segundos <= '0;
      Cuenta_Minutos  <= '0;
      Cuenta_Horas    <= '0;
      Cuenta_Year     <= '0;
      Cuenta_Mes      <= 4'd1;
      Cuenta_Dia      <= 5'd1;
      tick_1hz        <= 1'b0;
      load_err        <= 1'b0;
    end else begin
      tick_1hz <= tick;
      load_err <= (load_time && !time_ok) || (load_date && !date_ok);

      if (load_time) begin
        if (time_ok) begin
          Cuenta_Segundos <= set_seg;
          Cuenta_Minutos  <= set_min;
          Cuenta_Horas    <= set_hora;
        end
      end else if (tick) begin
        Cuenta_Segundos <= sec_wrap ? '0 : Cuenta_Segundos + 6'd1;
        if (sec_wrap) begin
          Cuenta_Minutos <= min_wrap ? '0 : Cuenta_Minutos + 6'd1;
          if (min_wrap) Cuenta_Horas <= hora_wrap ? '0 : Cuenta_Horas + 5'd1;
        end
      end

      if (load_date) begin
        if (date_ok) begin
          Cuenta_Year <= set_year;
          Cuenta_Mes  <= set_mes;
          Cuenta_Dia  <= set_dia;
        end
      end else if (day_carry) begin
        Cuenta_Dia <= dia_wrap ? 5'd1 : Cuenta_Dia + 5'd1;
        if (dia_wrap) begin
          Cuenta_Mes <= mes_wrap ? 4'd1 : Cuenta_Mes + 4'd1;
          if (mes_wrap) Cuenta_Year <= year_wrap ? '0 : Cuenta_Year + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_date_counter.sv
// Directed bench for time_date_counter with CLK_DIV=4.
module tb_time_date_counter;

  logic       clk = 1'b0;
  logic       reset, run, load_time, load_date;
  logic [5:0] set_seg, set_min;
  logic [4:0] set_hora;
  logic [6:0] set_year;
  logic [3:0] set_mes;
  logic [4:0] set_dia;
  logic [5:0] seg, mins;
  logic [4:0] hora;
  logic [6:0] year;
  logic [3:0] mes;
  logic [4:0] dia;
  logic       tick_1hz, load_err;

  int checks = 0;
  int failures = 0;

  time_date_counter #(.CLK_DIV(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .load_time       (load_time),
    .load_date       (load_date),
    .set_seg         (set_seg),
    .set_min         (set_min),
    .set_hora        (set_hora),
    .set_year        (set_year),
    .set_mes         (set_mes),
    .set_dia         (set_dia),
    .Cuenta_Segundos (seg),
    .Cuenta_Minutos  (mins),
    .Cuenta_Horas    (hora),
    .Cuenta_Year     (year),
    .Cuenta_Mes      (mes),
    .Cuenta_Dia      (dia),
    .tick_1hz        (tick_1hz),
    .load_err        (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] pack(input int h, input int m, input int s,
                                       input int y, input int mo, input int d);
    return {5'(h), 6'(m), 6'(s), 7'(y), 4'(mo), 5'(d)};
  endfunction

  function automatic logic [32:0] cur();
    return {hora, mins, seg, year, mes, dia};
  endfunction

  task automatic do_load(input logic lt, input logic ld, input int h, input int m, input int s,
                         input int y, input int mo, input int d);
    load_time = lt;
    load_date = ld;
    set_hora = 5'(h); set_min = 6'(m); set_seg = 6'(s);
    set_year = 7'(y); set_mes = 4'(mo); set_dia = 5'(d);
    @(negedge clk);
    load_time = 1'b0;
    load_date = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (cur() !== pack(0, 0, 0, 0, 1, 1)) begin
      failures++; $display("FAIL reset_init got=%h exp=%h", cur(), pack(0, 0, 0, 0, 1, 1));
    end
    checks++;
    if ({tick_1hz, load_err} !== 2'b00) begin
      failures++; $display("FAIL reset_init_flags got=%b exp=00", {tick_1hz, load_err});
    end
    do_load(1, 1, 12, 34, 56, 50, 6, 15);
    run = 1'b1;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cur() !== pack(0, 0, 0, 0, 1, 1)) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", cur(), pack(0, 0, 0, 0, 1, 1));
    end
    checks++;
    if ({tick_1hz, load_err} !== 2'b00) begin
      failures++; $display("FAIL reset_async_flags got=%b exp=00", {tick_1hz, load_err});
    end
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_rollover();
    do_load(1, 1, 23, 59, 58, 16, 12, 31);
    checks++;
    if (cur() !== pack(23, 59, 58, 16, 12, 31) || load_err !== 1'b0) begin
      failures++; $display("FAIL rollover_load got=%h err=%b exp=%h err=0",
                           cur(), load_err, pack(23, 59, 58, 16, 12, 31));
    end
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (tick_1hz !== ((i % 4) == 0)) begin
        failures++; $display("FAIL tick_period cycle=%0d got=%b exp=%b", i, tick_1hz, (i % 4) == 0);
      end
      if (i == 4) begin
        checks++;
        if (cur() !== pack(23, 59, 59, 16, 12, 31)) begin
          failures++; $display("FAIL rollover_first got=%h exp=%h", cur(), pack(23, 59, 59, 16, 12, 31));
        end
      end
      if (i == 8) begin
        checks++;
        if (cur() !== pack(0, 0, 0, 17, 1, 1)) begin
          failures++; $display("FAIL rollover_year got=%h exp=%h", cur(), pack(0, 0, 0, 17, 1, 1));
        end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_leap();
    do_load(1, 1, 23, 59, 59, 24, 2, 28);
    run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    checks++;
    if (cur() !== pack(0, 0, 0, 24, 2, 29) || tick_1hz !== 1'b1) begin
      failures++; $display("FAIL leap_feb29 got=%h tick=%b exp=%h tick=1", cur(), tick_1hz, pack(0, 0, 0, 24, 2, 29));
    end
    do_load(1, 1, 23, 59, 59, 23, 2, 28);
    run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    checks++;
    if (cur() !== pack(0, 0, 0, 23, 3, 1)) begin
      failures++; $display("FAIL nonleap_mar1 got=%h exp=%h", cur(), pack(0, 0, 0, 23, 3, 1));
    end
    do_load(0, 1, 0, 0, 0, 0, 2, 29);
    checks++;
    if (cur() !== pack(0, 0, 0, 0, 2, 29) || load_err !== 1'b0) begin
      failures++; $display("FAIL load_y0_feb29 got=%h err=%b exp=%h err=0", cur(), load_err, pack(0, 0, 0, 0, 2, 29));
    end
  endtask

  task automatic test_reject();
    do_load(0, 1, 0, 0, 0, 5, 4, 31);
    checks++;
    if (cur() !== pack(0, 0, 0, 0, 2, 29) || load_err !== 1'b1) begin
      failures++; $display("FAIL reject_apr31 got=%h err=%b exp=%h err=1", cur(), load_err, pack(0, 0, 0, 0, 2, 29));
    end
    @(negedge clk);
    checks++;
    if (load_err !== 1'b0) begin
      failures++; $display("FAIL load_err_pulse got=%b exp=0", load_err);
    end
    do_load(0, 1, 0, 0, 0, 5, 13, 1);
    checks++;
    if (cur() !== pack(0, 0, 0, 0, 2, 29) || load_err !== 1'b1) begin
      failures++; $display("FAIL reject_mes13 got=%h err=%b exp=%h err=1", cur(), load_err, pack(0, 0, 0, 0, 2, 29));
    end
    do_load(1, 0, 1, 60, 0, 0, 0, 0);
    checks++;
    if (cur() !== pack(0, 0, 0, 0, 2, 29) || load_err !== 1'b1) begin
      failures++; $display("FAIL reject_min60 got=%h err=%b exp=%h err=1", cur(), load_err, pack(0, 0, 0, 0, 2, 29));
    end
    do_load(1, 1, 1, 2, 3, 7, 4, 31);
    checks++;
    if (cur() !== pack(1, 2, 3, 0, 2, 29) || load_err !== 1'b1) begin
      failures++; $display("FAIL reject_date_only got=%h err=%b exp=%h err=1", cur(), load_err, pack(1, 2, 3, 0, 2, 29));
    end
  endtask

  task automatic test_collision();
    do_load(1, 1, 23, 59, 59, 10, 5, 31);
    run = 1'b1;
    repeat (3) @(negedge clk);
    do_load(1, 0, 10, 0, 0, 0, 0, 0);
    run = 1'b0;
    checks++;
    if (cur() !== pack(10, 0, 0, 10, 5, 31) || tick_1hz !== 1'b1 || load_err !== 1'b0) begin
      failures++; $display("FAIL collision got=%h tick=%b err=%b exp=%h tick=1 err=0",
                           cur(), tick_1hz, load_err, pack(10, 0, 0, 10, 5, 31));
    end
  endtask

  task automatic test_freeze();
    do_load(1, 0, 0, 0, 0, 0, 0, 0);
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== 6'd0 || tick_1hz !== 1'b0) begin
        failures++; $display("FAIL freeze cycle=%0d seg=%0d tick=%b exp seg=0 tick=0", i, seg, tick_1hz);
      end
    end
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (seg !== 6'd0 || tick_1hz !== 1'b0) begin
      failures++; $display("FAIL resume_early seg=%0d tick=%b exp seg=0 tick=0", seg, tick_1hz);
    end
    @(negedge clk);
    run = 1'b0;
    checks++;
    if (seg !== 6'd1 || tick_1hz !== 1'b1) begin
      failures++; $display("FAIL resume_phase seg=%0d tick=%b exp seg=1 tick=1", seg, tick_1hz);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; load_time = 1'b0; load_date = 1'b0;
    set_seg = '0; set_min = '0; set_hora = '0; set_year = '0; set_mes = '0; set_dia = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_rollover();
    test_leap();
    test_reject();
    test_collision();
    test_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
